// File: rtl/encoder_input_pkg.sv
// Shared types and default timing for the encoder/button input conditioner.
// Defaults assume a 10 MHz system clock.
package encoder_input_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    localparam int unsigned SYNC_STAGES_DEF       = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 10000;
    localparam int unsigned LONG_PRESS_CYCLES_DEF = 5000000;

endpackage

// File: rtl/debounce_channel.sv
// One asynchronous pin: synchroniser chain followed by a stable-count debouncer.
// The clean level changes only after DEBOUNCE_CYCLES consecutive synced mismatches.
module debounce_channel
    import encoder_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Plain shift chain, nothing between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Any return to agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clean <= RESET_LEVEL;
        end else if (sync_out == clean) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            clean <= sync_out;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/encoder_input_conditioner.sv
// Conditions encoder A/B and push-button pins into clk and classifies
// debounced button presses into single-cycle short/long pulses.
module encoder_input_conditioner
    import encoder_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a_raw,
    input  logic enc_b_raw,
    input  logic btn_raw_n,
    output logic enc_a_clean,
    output logic enc_b_clean,
    output logic btn_pressed,
    output logic btn_short,
    output logic btn_long
);

    localparam int unsigned      HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
    // Last count before the threshold; the long pulse launches as the counter reaches it.
    localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_PRESS_CYCLES - 2);

    logic btn_clean_n;

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b0)
    ) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_a_raw),
        .clean (enc_a_clean)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b0)
    ) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_b_raw),
        .clean (enc_b_clean)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_deb_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw_n),
        .clean (btn_clean_n)
    );

    assign btn_pressed = ~btn_clean_n;

    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              short_d, long_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            btn_short <= 1'b0;
            btn_long  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            btn_short <= short_d;
            btn_long  <= long_d;
        end
    end

    // Release is tested first so it wins over a coincident threshold.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (btn_pressed) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (!btn_pressed) begin
                    short_d = 1'b1;
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (hold_q == HOLD_ARM) begin
                    long_d  = 1'b1;
                    hold_d  = hold_q + HOLD_W'(1);
                    state_d = LONG_HELD;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_pressed) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Directed bench for encoder_input_conditioner with short debounce/long-press
// thresholds: vector table for the encoder paths, hand sequences for the button.
module tb_encoder_input_conditioner;
    import encoder_input_pkg::*;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic enc_a_raw = 1'b0;
    logic enc_b_raw = 1'b0;
    logic btn_raw_n = 1'b1;
    logic enc_a_clean, enc_b_clean, btn_pressed, btn_short, btn_long;

    int checks   = 0;
    int failures = 0;

    encoder_input_conditioner #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enc_a_raw   (enc_a_raw),
        .enc_b_raw   (enc_b_raw),
        .btn_raw_n   (btn_raw_n),
        .enc_a_clean (enc_a_clean),
        .enc_b_clean (enc_b_clean),
        .btn_pressed (btn_pressed),
        .btn_short   (btn_short),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    // Expected bits ordered {a_clean, b_clean, pressed, short, long}.
    typedef struct {
        logic       a;
        logic       b;
        logic       btn_n;
        int         cycles;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {enc_a_clean, enc_b_clean, btn_pressed, btn_short, btn_long};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_press(input int hold, output int t_rise, output int t_long,
                             output int t_short, output int n_long, output int n_short,
                             output int n_both);
        t_rise = -1; t_long = -1; t_short = -1;
        n_long = 0;  n_short = 0; n_both = 0;
        btn_raw_n = 1'b0;
        for (int c = 1; c <= hold + 20; c++) begin
            step(1);
            if (btn_pressed && t_rise < 0) t_rise = c;
            if (btn_long) begin
                n_long++;
                if (t_long < 0) t_long = c;
            end
            if (btn_short) begin
                n_short++;
                if (t_short < 0) t_short = c;
            end
            if (btn_long && btn_short) n_both++;
            if (c == hold) btn_raw_n = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise, t_long, t_short, n_long, n_short, n_both;
        int bounce_hits;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 3,  5'b00000};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 5,  5'b00000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1,  5'b10000};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 3,  5'b10000};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 10, 5'b10000};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4,  5'b10000};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2,  5'b11000};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3,  5'b11000};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1,  5'b10000};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 5,  5'b10000};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1,  5'b01000};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 2,  5'b01000};

        step(3);
        check("reset_state", 32'(outs()), 32'd0);
        rst_n = 1'b1;

        // Encoder latency, glitch rejection and simultaneous A/B changes.
        for (int i = 0; i < 12; i++) begin
            enc_a_raw = vecs[i].a;
            enc_b_raw = vecs[i].b;
            btn_raw_n = vecs[i].btn_n;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        enc_b_raw = 1'b0;
        step(8);

        run_press(10, t_rise, t_long, t_short, n_long, n_short, n_both);
        check("short_rise_latency", 32'(t_rise), 32'd6);
        check("short_count", 32'(n_short), 32'd1);
        check("short_no_long", 32'(n_long), 32'd0);
        check("short_timing", 32'(t_short - t_rise), 32'd11);
        check("short_fsm_idle", 32'(dut.state_q), 32'(IDLE));

        run_press(40, t_rise, t_long, t_short, n_long, n_short, n_both);
        check("long_timing", 32'(t_long - t_rise), 32'd20);
        check("long_count", 32'(n_long), 32'd1);
        check("long_no_short", 32'(n_short), 32'd0);
        check("long_exclusive", 32'(n_both), 32'd0);

        // Pressed for 19 cycles: release coincides with the threshold cycle.
        run_press(19, t_rise, t_long, t_short, n_long, n_short, n_both);
        check("thr19_short", 32'(n_short), 32'd1);
        check("thr19_no_long", 32'(n_long), 32'd0);
        check("thr19_timing", 32'(t_short - t_rise), 32'd20);

        run_press(20, t_rise, t_long, t_short, n_long, n_short, n_both);
        check("thr20_long", 32'(n_long), 32'd1);
        check("thr20_no_short", 32'(n_short), 32'd0);

        bounce_hits = 0;
        for (int i = 0; i < 10; i++) begin
            btn_raw_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                step(1);
                if (btn_pressed || btn_short || btn_long) bounce_hits++;
            end
        end
        check("bounce_filtered", 32'(bounce_hits), 32'd0);
        run_press(12, t_rise, t_long, t_short, n_long, n_short, n_both);
        check("bounce_rise_latency", 32'(t_rise), 32'd6);
        check("bounce_one_short", 32'(n_short), 32'd1);
        check("bounce_no_long", 32'(n_long), 32'd0);

        // Reset with debouncers and the hold counter active.
        enc_a_raw = 1'b1;
        enc_b_raw = 1'b0;
        btn_raw_n = 1'b0;
        step(8);
        check("pre_reset_state", 32'(outs()), 32'(5'b10100));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'(outs()), 32'd0);
        enc_a_raw = 1'b0;
        btn_raw_n = 1'b1;
        step(2);
        check("reset_held", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        step(10);
        check("post_reset", 32'(outs()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
